// File: rtl/seven_seg_pkg.sv
// Shared segment type and active-low glyph constants for seven-segment displays.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  // Active-low, bit0=a ... bit6=g
  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DARK = 7'h7F;

endpackage

// File: rtl/seg_glyph.sv
// Combinational decimal digit to active-low glyph; anything above 9 is dark.
module seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output seg_t               glyph_c
);

  always_comb begin
    glyph_c = SEG_DARK;
    case (digit)
      4'd0:    glyph_c = SEG_0;
      4'd1:    glyph_c = SEG_1;
      4'd2:    glyph_c = SEG_2;
      4'd3:    glyph_c = SEG_3;
      4'd4:    glyph_c = SEG_4;
      4'd5:    glyph_c = SEG_5;
      4'd6:    glyph_c = SEG_6;
      4'd7:    glyph_c = SEG_7;
      4'd8:    glyph_c = SEG_8;
      4'd9:    glyph_c = SEG_9;
      default: glyph_c = SEG_DARK;
    endcase
  end

endmodule

// File: rtl/seven_hex_decoder.sv
// Shows a 4-bit value as two registered decimal digits with blanking and
// optional leading-zero suppression on the tens digit.
module seven_hex_decoder
  import seven_seg_pkg::*;
#(
  parameter bit LEADING_ZERO = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [DIGIT_W-1:0] i_hex,
  input  logic               i_blank,
  output seg_t               o_seven_ten,
  output seg_t               o_seven_one
);

  logic [DIGIT_W-1:0] ten_digit_c;
  logic [DIGIT_W-1:0] one_digit_c;
  seg_t               ten_glyph_c;
  seg_t               one_glyph_c;
  seg_t               ten_next_c;
  seg_t               one_next_c;

  // Decimal split: values 10-15 carry a 1 into the tens digit
  always_comb begin
    ten_digit_c = '0;
    one_digit_c = i_hex;
    if (i_hex >= DIGIT_W'(10)) begin
      ten_digit_c = DIGIT_W'(1);
      one_digit_c = DIGIT_W'(i_hex - DIGIT_W'(10));
    end
  end

  seg_glyph u_ten_glyph (
    .digit   (ten_digit_c),
    .glyph_c (ten_glyph_c)
  );

  seg_glyph u_one_glyph (
    .digit   (one_digit_c),
    .glyph_c (one_glyph_c)
  );

  always_comb begin
    ten_next_c = ten_glyph_c;
    one_next_c = one_glyph_c;
    if (!LEADING_ZERO && (ten_digit_c == '0)) begin
      ten_next_c = SEG_DARK;
    end
    if (i_blank) begin
      ten_next_c = SEG_DARK;
      one_next_c = SEG_DARK;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seven_ten <= SEG_DARK;
      o_seven_one <= SEG_DARK;
    end else if (i_en) begin
      o_seven_ten <= ten_next_c;
      o_seven_one <= one_next_c;
    end
  end

endmodule

// File: tb/tb_seven_hex_decoder.sv
// Randomized and directed checks of seven_hex_decoder against a decimal-digit model,
// with one instance per LEADING_ZERO setting.
module tb_seven_hex_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] hex = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] ten_lz, one_lz, ten_nz, one_nz;
  int         total = 0;
  int         bad = 0;
  logic [6:0] exp_ten_lz, exp_one_lz, exp_ten_nz, exp_one_nz;

  always #5 clk = ~clk;

  seven_hex_decoder #(.LEADING_ZERO(1'b1)) dut_lz (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_hex(hex), .i_blank(blank),
    .o_seven_ten(ten_lz), .o_seven_one(one_lz)
  );

  seven_hex_decoder #(.LEADING_ZERO(1'b0)) dut_nz (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_hex(hex), .i_blank(blank),
    .o_seven_ten(ten_nz), .o_seven_one(one_nz)
  );

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] table_g [10];
    table_g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return table_g[d];
  endfunction

  function automatic logic [6:0] model_ten(input int h, input logic b, input logic lz);
    if (b) return 7'h7F;
    if (h / 10 == 1) return glyph(1);
    return lz ? glyph(0) : 7'h7F;
  endfunction

  function automatic logic [6:0] model_one(input int h, input logic b);
    if (b) return 7'h7F;
    return glyph(h % 10);
  endfunction

  // Advance one edge and update the expected registers for both instances
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_ten_lz = 7'h7F; exp_one_lz = 7'h7F;
      exp_ten_nz = 7'h7F; exp_one_nz = 7'h7F;
    end else if (en) begin
      exp_ten_lz = model_ten(int'(hex), blank, 1'b1);
      exp_one_lz = model_one(int'(hex), blank);
      exp_ten_nz = model_ten(int'(hex), blank, 1'b0);
      exp_one_nz = model_one(int'(hex), blank);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; hex = 4'd5; blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (ten_lz !== 7'h7F || one_lz !== 7'h7F) begin
        bad++;
        $display("FAIL reset cyc%0d: got %h/%h want 7f/7f", i, ten_lz, one_lz);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (ten_lz !== 7'h40 || one_lz !== 7'h12) begin
      bad++;
      $display("FAIL reset_release: got %h/%h want 40/12", ten_lz, one_lz);
    end
  endtask

  task automatic test_sweep();
    en = 1'b1; blank = 1'b0;
    for (int h = 0; h < 16; h++) begin
      hex = 4'(h);
      tick();
      total++;
      if (ten_lz !== model_ten(h, 1'b0, 1'b1) || one_lz !== model_one(h, 1'b0)) begin
        bad++;
        $display("FAIL sweep hex=%0d: got %h/%h want %h/%h", h, ten_lz, one_lz,
                 model_ten(h, 1'b0, 1'b1), model_one(h, 1'b0));
      end
      total++;
      if (ten_nz !== model_ten(h, 1'b0, 1'b0) || one_nz !== model_one(h, 1'b0)) begin
        bad++;
        $display("FAIL sweep_nz hex=%0d: got %h/%h want %h/%h", h, ten_nz, one_nz,
                 model_ten(h, 1'b0, 1'b0), model_one(h, 1'b0));
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b1; blank = 1'b0; hex = 4'd7;
    tick();
    en = 1'b0; hex = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ten_lz !== 7'h40 || one_lz !== 7'h78) begin
        bad++;
        $display("FAIL hold cyc%0d: got %h/%h want 40/78", i, ten_lz, one_lz);
      end
    end
  endtask

  task automatic test_blank();
    en = 1'b1; blank = 1'b1; hex = 4'd12;
    tick();
    total++;
    if (ten_lz !== 7'h7F || one_lz !== 7'h7F) begin
      bad++;
      $display("FAIL blank: got %h/%h want 7f/7f", ten_lz, one_lz);
    end
    blank = 1'b0;
    tick();
    total++;
    if (ten_lz !== 7'h79 || one_lz !== 7'h24) begin
      bad++;
      $display("FAIL unblank: got %h/%h want 79/24", ten_lz, one_lz);
    end
  endtask

  task automatic test_no_leading_zero();
    en = 1'b1; blank = 1'b0; hex = 4'd4;
    tick();
    total++;
    if (ten_nz !== 7'h7F || one_nz !== 7'h19) begin
      bad++;
      $display("FAIL nlz_4: got %h/%h want 7f/19", ten_nz, one_nz);
    end
    hex = 4'd14;
    tick();
    total++;
    if (ten_nz !== 7'h79 || one_nz !== 7'h19) begin
      bad++;
      $display("FAIL nlz_14: got %h/%h want 79/19", ten_nz, one_nz);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; en = 1'b1; hex = 4'd8; blank = 1'b0;
    tick();
    total++;
    if (ten_lz !== 7'h7F || one_lz !== 7'h7F || ten_nz !== 7'h7F || one_nz !== 7'h7F) begin
      bad++;
      $display("FAIL reset_priority: got %h/%h %h/%h want 7f/7f", ten_lz, one_lz, ten_nz, one_nz);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst   = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 3) != 0);
      blank = ($urandom_range(0, 7) == 0);
      hex   = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (ten_lz !== exp_ten_lz || one_lz !== exp_one_lz ||
          ten_nz !== exp_ten_nz || one_nz !== exp_one_nz) begin
        bad++;
        $display("FAIL random cyc%0d: got %h/%h %h/%h want %h/%h %h/%h", i,
                 ten_lz, one_lz, ten_nz, one_nz, exp_ten_lz, exp_one_lz, exp_ten_nz, exp_one_nz);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sweep();
    test_hold();
    test_blank();
    test_no_leading_zero();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
